input_port_router: RTL and testbench

Per-input-port buffer and XY route computer for the simple mesh XY switch. It accepts single-flit packets from one neighbour or the local resource and stores them in a small FIFO. It decodes the head flit's destination into a one-hot request toward one of the five output-port arbiters, and it pops the head when that arbiter grants this input. One instance sits on each of the five switch inputs, upstream of the output arbiters and crossbar muxes.

---
 rtl/input_port_router.sv | 99 +++++++++
 tb/tb_input_port_router.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/input_port_router.sv
// Input-port flit buffer for the mesh XY switch: a small FIFO whose head flit is
// decoded (X first, then Y) into a one-hot request toward the output arbiters.
module input_port_router #(
   parameter int DATA_WIDTH   = 8,
   parameter int X_ADDR_WIDTH = 2,
   parameter int Y_ADDR_WIDTH = 2,
   parameter int X_COORD      = 0,
   parameter int Y_COORD      = 0,
   parameter int FIFO_DEPTH   = 4,
   parameter int PORT_N       = 5
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic [DATA_WIDTH-1:0]           data_i,
   input  logic                            wr_en_i,
   output logic                            rdy_o,
   output logic [DATA_WIDTH-1:0]           data_o,
   output logic [PORT_N-1:0]               route_o,
   input  logic [PORT_N-1:0]               grant_i,
   output logic [$clog2(FIFO_DEPTH):0]     count_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam int RESOURCE = 0;
   localparam int WEST     = 1;
   localparam int EAST     = 2;
   localparam int NORTH    = 3;
   localparam int SOUTH    = 4;

   localparam logic [CNT_W-1:0]        DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [X_ADDR_WIDTH-1:0] X_C     = X_ADDR_WIDTH'(X_COORD);
   localparam logic [Y_ADDR_WIDTH-1:0] Y_C     = Y_ADDR_WIDTH'(Y_COORD);

   logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [CNT_W-1:0]        count;
   logic [DATA_WIDTH-1:0]   head;
   logic [X_ADDR_WIDTH-1:0] dst_x;
   logic [Y_ADDR_WIDTH-1:0] dst_y;
   logic                    empty;
   logic                    push;
   logic                    pop;

   assign empty   = (count == '0);
   assign rdy_o   = (count != DEPTH_C);
   assign count_o = count;
   assign head    = mem[rd_ptr];
   assign dst_x   = head[DATA_WIDTH-1 -: X_ADDR_WIDTH];
   assign dst_y   = head[DATA_WIDTH-X_ADDR_WIDTH-1 -: Y_ADDR_WIDTH];
   assign data_o  = empty ? '0 : head;

   // A full FIFO never accepts, even when the head is popped in the same cycle.
   assign push = wr_en_i && rdy_o;
   assign pop  = |(grant_i & route_o);

   always_comb begin
      route_o = '0;
      if (!empty) begin
         if (dst_x > X_C)
            route_o[EAST] = 1'b1;
         else if (dst_x < X_C)
            route_o[WEST] = 1'b1;
         else if (dst_y > Y_C)
            route_o[NORTH] = 1'b1;
         else if (dst_y < Y_C)
            route_o[SOUTH] = 1'b1;
         else
            route_o[RESOURCE] = 1'b1;
      end
   end

   // Storage is never reset; data_o is masked while empty instead.
   always_ff @(posedge clk_i) begin
      if (push)
         mem[wr_ptr] <= data_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_input_port_router.sv
// Randomized self-checking bench for input_port_router at switch (1,1), using a
// queue-based reference of the flit buffer and an arithmetic XY route rule.
module tb_input_port_router;

   localparam int DEPTH = 4;

   logic       clk_i   = 1'b0;
   logic       rst_ni  = 1'b0;
   logic       wr_en_i = 1'b0;
   logic [7:0] data_i  = '0;
   logic [4:0] grant_i = '0;
   logic       rdy_o;
   logic [7:0] data_o;
   logic [4:0] route_o;
   logic [2:0] count_o;

   logic [7:0] q [$];
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   input_port_router #(
      .DATA_WIDTH(8), .X_ADDR_WIDTH(2), .Y_ADDR_WIDTH(2),
      .X_COORD(1), .Y_COORD(1), .FIFO_DEPTH(DEPTH), .PORT_N(5)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .data_i(data_i), .wr_en_i(wr_en_i),
      .rdy_o(rdy_o), .data_o(data_o), .route_o(route_o), .grant_i(grant_i),
      .count_o(count_o)
   );

   // Output port bit for a flit at switch (1,1): X resolved before Y.
   function automatic logic [4:0] route_of(input logic [7:0] f);
      int dx;
      int dy;
      dx = int'(f[7:6]);
      dy = int'(f[5:4]);
      if (dx > 1)      return 5'b00100;
      else if (dx < 1) return 5'b00010;
      else if (dy > 1) return 5'b01000;
      else if (dy < 1) return 5'b10000;
      else             return 5'b00001;
   endfunction

   // Expected {rdy, count, route, data} from the reference queue.
   function automatic logic [16:0] model_view();
      if (q.size() == 0)
         return {1'b1, 3'd0, 5'd0, 8'd0};
      return {q.size() < DEPTH, 3'(q.size()), route_of(q[0]), q[0]};
   endfunction

   task automatic cycle(input logic wr, input logic [7:0] d, input logic [4:0] g);
      bit push;
      bit pop;
      wr_en_i = wr;
      data_i  = d;
      grant_i = g;
      push = wr && (q.size() < DEPTH);
      pop  = (q.size() > 0) && ((g & route_of(q[0])) != 5'd0);
      @(posedge clk_i);
      #1;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(d);
      wr_en_i = 1'b0;
      grant_i = '0;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      n_cmp++;
      if ({rdy_o, count_o, route_o, data_o} !== {1'b1, 3'd0, 5'd0, 8'd0}) begin
         n_err++;
         $display("[TB] FAIL reset_idle got=%h want=%h", {rdy_o, count_o, route_o, data_o}, {1'b1, 3'd0, 5'd0, 8'd0});
      end
      rst_ni = 1'b1;
      q.delete();
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom), 5'd0);
      n_cmp++;
      if (count_o !== 3'd3) begin
         n_err++;
         $display("[TB] FAIL reset_preload count got=%0d want=3", count_o);
      end
      #2 rst_ni = 1'b0;
      #1;
      q.delete();
      n_cmp++;
      if ({rdy_o, count_o, route_o, data_o} !== {1'b1, 3'd0, 5'd0, 8'd0}) begin
         n_err++;
         $display("[TB] FAIL reset_async got=%h want=%h", {rdy_o, count_o, route_o, data_o}, {1'b1, 3'd0, 5'd0, 8'd0});
      end
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic test_route();
      logic [1:0] dxs  [5] = '{2'd2, 2'd0, 2'd1, 2'd1, 2'd1};
      logic [1:0] dys  [5] = '{2'd1, 2'd1, 2'd2, 2'd0, 2'd1};
      logic [4:0] want [5] = '{5'b00100, 5'b00010, 5'b01000, 5'b10000, 5'b00001};
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, {dxs[i], dys[i], 4'($urandom)}, 5'd0);
         n_cmp++;
         if (route_o !== want[i] || data_o !== q[0]) begin
            n_err++;
            $display("[TB] FAIL route_%0d route got=%b want=%b data got=%h want=%h", i, route_o, want[i], data_o, q[0]);
         end
         cycle(1'b0, 8'd0, want[i]);
         n_cmp++;
         if (count_o !== 3'd0 || route_o !== 5'd0) begin
            n_err++;
            $display("[TB] FAIL route_pop_%0d count got=%0d route got=%b want count=0 route=00000", i, count_o, route_o);
         end
      end
   endtask

   task automatic test_fill();
      logic [7:0] sent [5];
      for (int i = 0; i < 5; i++) begin
         sent[i] = 8'($urandom);
         cycle(1'b1, sent[i], 5'd0);
      end
      n_cmp++;
      if (count_o !== 3'd4 || rdy_o !== 1'b0) begin
         n_err++;
         $display("[TB] FAIL fill_full count got=%0d rdy got=%b want count=4 rdy=0", count_o, rdy_o);
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (data_o !== sent[i] || route_o !== route_of(sent[i])) begin
            n_err++;
            $display("[TB] FAIL fill_order_%0d data got=%h want=%h route got=%b want=%b", i, data_o, sent[i], route_o, route_of(sent[i]));
         end
         cycle(1'b0, 8'd0, route_of(sent[i]));
      end
      n_cmp++;
      if (count_o !== 3'd0 || data_o !== 8'd0) begin
         n_err++;
         $display("[TB] FAIL fill_drained count got=%0d data got=%h want count=0 data=00", count_o, data_o);
      end
   endtask

   task automatic test_wrong_grant();
      cycle(1'b1, {2'd2, 2'($urandom), 4'($urandom)}, 5'd0);
      cycle(1'b0, 8'd0, 5'b01000);
      n_cmp++;
      if (count_o !== 3'd1 || route_o !== 5'b00100) begin
         n_err++;
         $display("[TB] FAIL wrong_grant count got=%0d route got=%b want count=1 route=00100", count_o, route_o);
      end
      cycle(1'b0, 8'd0, 5'b00100);
      n_cmp++;
      if (count_o !== 3'd0) begin
         n_err++;
         $display("[TB] FAIL right_grant count got=%0d want=0", count_o);
      end
   endtask

   task automatic test_back_to_back();
      cycle(1'b1, 8'($urandom), 5'd0);
      cycle(1'b1, 8'($urandom), 5'd0);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 8'($urandom), route_of(q[0]) | 5'($urandom));
         n_cmp++;
         if (count_o !== 3'd2 || data_o !== q[0]) begin
            n_err++;
            $display("[TB] FAIL simul_%0d count got=%0d want=2 data got=%h want=%h", i, count_o, data_o, q[0]);
         end
      end
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (data_o !== q[0]) begin
            n_err++;
            $display("[TB] FAIL simul_drain_%0d data got=%h want=%h", i, data_o, q[0]);
         end
         cycle(1'b0, 8'd0, route_of(q[0]));
      end
   endtask

   task automatic test_full_grant();
      logic [7:0] second;
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom), 5'd0);
      second  = q[1];
      wr_en_i = 1'b1;
      grant_i = route_of(q[0]);
      #1;
      n_cmp++;
      if (rdy_o !== 1'b0) begin
         n_err++;
         $display("[TB] FAIL full_rdy_comb got=%b want=0", rdy_o);
      end
      cycle(1'b1, 8'($urandom), route_of(q[0]));
      n_cmp++;
      if (count_o !== 3'd3 || rdy_o !== 1'b1 || data_o !== second) begin
         n_err++;
         $display("[TB] FAIL full_grant count got=%0d rdy got=%b data got=%h want count=3 rdy=1 data=%h", count_o, rdy_o, data_o, second);
      end
      while (q.size() > 0) cycle(1'b0, 8'd0, route_of(q[0]));
   endtask

   task automatic test_random();
      logic [4:0] g;
      for (int i = 0; i < 300; i++) begin
         g = 5'($urandom);
         if (q.size() > 0 && $urandom_range(0, 1) == 1) g = route_of(q[0]);
         cycle(1'($urandom), 8'($urandom), g);
         n_cmp++;
         if ({rdy_o, count_o, route_o, data_o} !== model_view()) begin
            n_err++;
            $display("[TB] FAIL random_%0d got=%h want=%h", i, {rdy_o, count_o, route_o, data_o}, model_view());
         end
      end
   endtask

   initial begin
      test_reset();
      test_route();
      test_fill();
      test_wrong_grant();
      test_back_to_back();
      test_full_grant();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
